// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer for the 5-stage pipeline.
// Owns the fetch PC and the IF/ID register, talks to a variable-latency
// instruction memory over a req/ack handshake, parks a returned word while
// decode is stalled and drains fetches made stale by an EX redirect.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// perf_wait_cnt / perf_kill_cnt counters and their ports.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             PC_srcE,
  input  logic [31:0]      PC_targetE,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      instrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PC_plus4D,
  output logic             imem_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_wait_cnt,
  output logic [CNT_W-1:0] perf_kill_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] redir_q;
  logic [31:0] buf_q;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        new_valid;
  logic [31:0] new_word;
  logic        unused_target_lsbs;

  // Redirect targets are forced to word alignment, so pc_q never has low bits set.
  assign target             = {PC_targetE[31:2], 2'b00};
  assign unused_target_lsbs = ^PC_targetE[1:0];
  assign pc_plus4           = pc_q + 32'd4;

  // Memory side: request in FETCH and DRAIN, never while reset is asserted.
  assign mem_req   = rst_n & (state != HOLD);
  assign mem_addr  = pc_q;
  assign imem_busy = mem_req & ~mem_ack;

  // A word is ready for decode from a live ack in FETCH or from the park buffer.
  assign new_valid = ((state == FETCH) && mem_ack) || (state == HOLD);
  assign new_word  = (state == HOLD) ? buf_q : mem_rdata;

  // Fetch FSM, PC, redirect/park registers and the IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      redir_q   <= 32'd0;
      buf_q     <= 32'd0;
      instrD    <= 32'd0;
      PCD       <= 32'd0;
      PC_plus4D <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            if (PC_srcE) begin
              pc_q <= target;
            end else if (stallD) begin
              buf_q <= mem_rdata;
              state <= HOLD;
            end else begin
              pc_q <= pc_plus4;
            end
          end else if (PC_srcE) begin
            redir_q <= target;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (PC_srcE) begin
            redir_q <= target;
          end
          if (mem_ack) begin
            pc_q  <= PC_srcE ? target : redir_q;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (PC_srcE) begin
            buf_q <= 32'd0;
            pc_q  <= target;
            state <= FETCH;
          end else if (!stallD) begin
            pc_q  <= pc_plus4;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase

      if (!stallD) begin
        if (flushD || PC_srcE || !new_valid) begin
          instrD    <= 32'd0;
          PCD       <= 32'd0;
          PC_plus4D <= 32'd0;
        end else begin
          instrD    <= new_word;
          PCD       <= pc_q;
          PC_plus4D <= pc_plus4;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic kill_ack;

  // An ack is wasted when draining a stale fetch or when it meets a redirect.
  assign kill_ack = mem_req & mem_ack &
                    ((state == DRAIN) || ((state == FETCH) && PC_srcE));

  // Saturating counters for memory wait cycles and discarded fetches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_wait_cnt <= '0;
      perf_kill_cnt <= '0;
    end else begin
      if (imem_busy && (perf_wait_cnt != '1)) begin
        perf_wait_cnt <= perf_wait_cnt + CNT_W'(1);
      end
      if (kill_ack && (perf_kill_cnt != '1)) begin
        perf_kill_cnt <= perf_kill_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a behavioural instruction memory
// with per-request latency plus a transaction-level model of the fetch stream.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallD = 1'b0;
  logic        flushD = 1'b0;
  logic        PC_srcE = 1'b0;
  logic [31:0] PC_targetE = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic [31:0] PC_plus4D;
  logic        imem_busy;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_wait_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stallD     (stallD),
    .flushD     (flushD),
    .PC_srcE    (PC_srcE),
    .PC_targetE (PC_targetE),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instrD     (instrD),
    .PCD        (PCD),
    .PC_plus4D  (PC_plus4D),
    .imem_busy  (imem_busy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_wait_cnt (perf_wait_cnt),
    .perf_kill_cnt (perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Compare one observed value against its expectation.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory environment: lat_mode < 0 picks a random wait (0..3) per request.
  int          lat_mode   = 0;
  bit          const_mode = 1'b0;
  int          mem_cnt    = 0;
  int          mem_lat    = 0;
  logic [31:0] mem_hold_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_mode) return 32'h0000_0013;
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: what the fetch unit has in flight and what decode sees.
  logic [31:0] m_pc      = 32'd0;   // address being / to be fetched
  bit          m_stale   = 1'b0;    // outstanding fetch will be thrown away
  logic [31:0] m_after   = 32'd0;   // where fetching resumes after the stale one
  bit          m_parked  = 1'b0;    // a fetched word waits for decode to unstall
  logic [31:0] m_park_w  = 32'd0;
  logic [31:0] m_instr   = 32'd0;
  logic [31:0] m_pcd     = 32'd0;
  logic [31:0] m_pc4     = 32'd0;
  logic [31:0] m_wait    = 32'd0;
  logic [31:0] m_kill    = 32'd0;

  task automatic model_step(input bit r, input bit s, input bit f, input bit j,
                            input logic [31:0] t, input bit req, input bit ack);
    bit          have_new = 1'b0;
    logic [31:0] word     = 32'd0;
    logic [31:0] at       = 32'd0;
    logic [31:0] tgt      = t & 32'hFFFF_FFFC;
    bit          acked    = req && ack;
    if (!r) begin
      m_pc = 32'd0; m_stale = 1'b0; m_after = 32'd0; m_parked = 1'b0;
      m_instr = 32'd0; m_pcd = 32'd0; m_pc4 = 32'd0; m_wait = 32'd0; m_kill = 32'd0;
      return;
    end
    if (req && !ack && m_wait != 32'hFFFF_FFFF) m_wait++;
    if (m_parked) begin
      if (j) begin
        m_parked = 1'b0; m_pc = tgt;
      end else if (!s) begin
        have_new = 1'b1; word = m_park_w; at = m_pc; m_pc = m_pc + 32'd4; m_parked = 1'b0;
      end
    end else if (m_stale) begin
      if (j) m_after = tgt;
      if (acked) begin
        m_kill++; m_pc = m_after; m_stale = 1'b0;
      end
    end else if (acked) begin
      if (j) begin
        m_kill++; m_pc = tgt;
      end else if (s) begin
        m_parked = 1'b1; m_park_w = mem_word(m_pc);
      end else begin
        have_new = 1'b1; word = mem_word(m_pc); at = m_pc; m_pc = m_pc + 32'd4;
      end
    end else if (j) begin
      m_stale = 1'b1; m_after = tgt;
    end
    if (!s) begin
      if (f || j || !have_new) begin
        m_instr = 32'd0; m_pcd = 32'd0; m_pc4 = 32'd0;
      end else begin
        m_instr = word; m_pcd = at; m_pc4 = at + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive inputs, answer the request, compare, advance the model.
  task automatic step(input bit r, input bit s, input bit f, input bit j, input logic [31:0] t);
    bit exp_req;
    @(negedge clk);
    rst_n = r; stallD = s; flushD = f; PC_srcE = j; PC_targetE = t;
    #1;
    if (mem_req) begin
      if (mem_cnt == 0) begin
        mem_lat       = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
        mem_hold_addr = mem_addr;
      end else begin
        check_val("addr_stable", mem_addr, mem_hold_addr);
      end
      mem_ack = (mem_cnt == mem_lat);
    end else begin
      mem_ack = 1'b0;
    end
    mem_rdata = mem_ack ? mem_word(mem_addr) : $urandom();
    #1;
    exp_req = r && !m_parked;
    check_val("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
    if (exp_req) check_val("mem_addr", mem_addr, m_pc);
    check_val("imem_busy", {31'd0, imem_busy}, {31'd0, exp_req && !mem_ack});
    check_val("instrD", instrD, m_instr);
    check_val("PCD", PCD, m_pcd);
    check_val("PC_plus4D", PC_plus4D, m_pc4);
`ifdef FETCH_PERF_CNT_EN
    check_val("perf_wait", perf_wait_cnt, m_wait);
    check_val("perf_kill", perf_kill_cnt, m_kill);
`endif
    if (mem_req && !mem_ack) mem_cnt++;
    else mem_cnt = 0;
    model_step(r, s, f, j, t, exp_req, mem_ack);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    // Zero-wait memory returning 0x13 everywhere: one instruction per cycle.
    const_mode = 1'b1; lat_mode = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(6);
    check_val("zw_pcd_seq", PCD, 32'd16);

    // Three-cycle latency: two bubbles per instruction.
    const_mode = 1'b0; lat_mode = 2;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(7);

    // Redirect to 0x100 during the second wait cycle of the fetch at 0x8.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(7);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_val("plan_wait", perf_wait_cnt, 32'd6);
    check_val("plan_kill", perf_kill_cnt, 32'd1);
`endif
    idle(6);

    // Decode stalled for four cycles as the word at 0x10 returns.
    lat_mode = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("hold_release", instrD, 32'hDEAD_BEEF);

    // Reset for one edge in the middle of a wait.
    lat_mode = 2;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    idle(5);

    // Randomised traffic with random latency, stalls, flushes, redirects, resets.
    lat_mode = -1;
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0),
           $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
